// File: rtl/upsample_region_reader.sv
// ---------------------------------------------------------------------------
// upsample_region_reader
//
// Address generator and read port for the overlay-region image buffer. The
// display stage asks for one output pixel per cycle via i_region_active; this
// block turns that request stream into read addresses for a SRC_W x SRC_H
// source RAM. Each source pixel is repeated S = 2^SCALE_LOG2 times
// horizontally, and each source line is replayed S times vertically
// (nearest-neighbour upsampling). RAM data is passed straight back to the
// display stage.
//
// Ports:
//   pclk            pixel clock (only clock)
//   rst_n           asynchronous active-low reset
//   i_ram_addr_rst  one-cycle frame-start pulse, synchronous clear of the walk
//   i_region_active display stage requests one output pixel this cycle
//   o_rd_en         RAM read enable
//   o_rd_addr       RAM read address (valid in the same cycle as the request)
//   i_rd_data       RAM read data, synchronous RAM with 1-cycle latency
//   o_region_data   pixel to the display stage (pass-through of i_rd_data)
//   o_frame_done    one-cycle pulse after the last pixel of the frame
//   o_overrun       sticky: a request arrived after the frame had completed
// ---------------------------------------------------------------------------
module upsample_region_reader #(
  parameter int SRC_W      = 64,
  parameter int SRC_H      = 64,
  parameter int SCALE_LOG2 = 2,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              i_ram_addr_rst,
  input  logic              i_region_active,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_region_data,
  output logic              o_frame_done,
  output logic              o_overrun
);

  localparam int S   = 1 << SCALE_LOG2;
  localparam int SXW = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int XW  = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int YW  = (SRC_H > 1) ? $clog2(SRC_H) : 1;

  localparam logic [SXW-1:0]    SUB_LAST  = SXW'(S - 1);
  localparam logic [XW-1:0]     X_LAST    = XW'(SRC_W - 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(SRC_H - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SRC_W);

  // Walk state: sub-pixel/sub-line repeat counters, source coordinates and
  // the address of the first pixel of the current source line.
  logic [SXW-1:0]    sub_x, sub_x_nxt;
  logic [XW-1:0]     src_x, src_x_nxt;
  logic [SXW-1:0]    sub_y, sub_y_nxt;
  logic [YW-1:0]     src_y, src_y_nxt;
  logic [ADDR_W-1:0] line_base, line_base_nxt;
  logic              done, done_nxt;
  logic              frame_done_q, frame_done_nxt;
  logic              overrun, overrun_nxt;

  logic advance;
  logic sub_x_wrap;
  logic line_end;
  logic frame_end;

  // State register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sub_x        <= '0;
      src_x        <= '0;
      sub_y        <= '0;
      src_y        <= '0;
      line_base    <= '0;
      done         <= 1'b0;
      frame_done_q <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sub_x        <= sub_x_nxt;
      src_x        <= src_x_nxt;
      sub_y        <= sub_y_nxt;
      src_y        <= src_y_nxt;
      line_base    <= line_base_nxt;
      done         <= done_nxt;
      frame_done_q <= frame_done_nxt;
      overrun      <= overrun_nxt;
    end
  end

  // Wrap conditions of the nested counters. A frame-start pulse wins over a
  // simultaneous request, so that request does not move the walk.
  always_comb begin
    advance    = i_region_active & ~done & ~i_ram_addr_rst;
    sub_x_wrap = (sub_x == SUB_LAST);
    line_end   = sub_x_wrap && (src_x == X_LAST);
    frame_end  = line_end && (sub_y == SUB_LAST) && (src_y == Y_LAST);
  end

  // Next-state logic. The frame_done pulse is driven only by the final
  // advance, so a frame-start pulse in the following cycle cannot cancel it.
  always_comb begin
    sub_x_nxt      = sub_x;
    src_x_nxt      = src_x;
    sub_y_nxt      = sub_y;
    src_y_nxt      = src_y;
    line_base_nxt  = line_base;
    done_nxt       = done;
    overrun_nxt    = overrun;
    frame_done_nxt = advance & frame_end;

    if (i_ram_addr_rst) begin
      sub_x_nxt     = '0;
      src_x_nxt     = '0;
      sub_y_nxt     = '0;
      src_y_nxt     = '0;
      line_base_nxt = '0;
      done_nxt      = 1'b0;
      overrun_nxt   = 1'b0;
    end else begin
      if (i_region_active && done)
        overrun_nxt = 1'b1;
      if (advance) begin
        if (!sub_x_wrap) begin
          sub_x_nxt = sub_x + SXW'(1);
        end else begin
          sub_x_nxt = '0;
          if (!line_end) begin
            src_x_nxt = src_x + XW'(1);
          end else begin
            // End of an output line: replay the source line until it has
            // been shown S times, then step to the next source line.
            src_x_nxt = '0;
            if (sub_y != SUB_LAST) begin
              sub_y_nxt = sub_y + SXW'(1);
            end else begin
              sub_y_nxt = '0;
              if (src_y != Y_LAST) begin
                src_y_nxt     = src_y + YW'(1);
                line_base_nxt = line_base + LINE_STEP;
              end else begin
                src_y_nxt     = '0;
                line_base_nxt = '0;
                done_nxt      = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Outputs. The read enable is also gated by rst_n so nothing is read
  // while the block is held in reset.
  always_comb begin
    o_rd_en       = i_region_active & ~done & rst_n;
    o_rd_addr     = line_base + ADDR_W'(src_x);
    o_region_data = i_rd_data;
    o_frame_done  = frame_done_q;
    o_overrun     = overrun;
  end

endmodule

// File: tb/tb_upsample_region_reader.sv
// ---------------------------------------------------------------------------
// tb_upsample_region_reader
//
// Scoreboard bench for upsample_region_reader with default parameters
// (64x64 source, x4 upscale, 256x256 output). The stimulus side pushes the
// expected read address of every request into a queue; a monitor pops and
// compares whenever the DUT asserts o_rd_en, and checks the returned pixel
// one cycle later against a bench-side RAM content function.
// ---------------------------------------------------------------------------
module tb_upsample_region_reader;

  logic        pclk;
  logic        rst_n;
  logic        i_ram_addr_rst;
  logic        i_region_active;
  logic        o_rd_en;
  logic [11:0] o_rd_addr;
  logic [7:0]  i_rd_data;
  logic [7:0]  o_region_data;
  logic        o_frame_done;
  logic        o_overrun;

  int vectors     = 0;
  int miscompares = 0;
  int fd_count    = 0;

  int pos        = 0;
  bit model_done = 0;
  int exp_q[$];

  upsample_region_reader dut (
    .pclk            (pclk),
    .rst_n           (rst_n),
    .i_ram_addr_rst  (i_ram_addr_rst),
    .i_region_active (i_region_active),
    .o_rd_en         (o_rd_en),
    .o_rd_addr       (o_rd_addr),
    .i_rd_data       (i_rd_data),
    .o_region_data   (o_region_data),
    .o_frame_done    (o_frame_done),
    .o_overrun       (o_overrun)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // RAM contents: an arbitrary but address-dependent pattern
  function automatic logic [7:0] ram_word(input int a);
    return 8'((a * 7) ^ (a >> 5) ^ 8'h5A);
  endfunction

  // Output pixel p (raster order in the 256x256 window) reads source pixel
  // (x/4, y/4) of the 64-wide source image.
  function automatic int exp_addr(input int p);
    int ox, oy;
    ox = p % 256;
    oy = p / 256;
    return (oy / 4) * 64 + (ox / 4);
  endfunction

  // Synchronous RAM model, 1-cycle latency
  always @(posedge pclk) begin
    if (o_rd_en)
      i_rd_data <= ram_word(int'(o_rd_addr));
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One request cycle; inputs change 1 time unit after the rising edge
  task automatic applyStimulus(input logic with_rst);
    @(posedge pclk);
    #1;
    i_region_active = 1'b1;
    i_ram_addr_rst  = with_rst;
    if (!model_done)
      exp_q.push_back(exp_addr(pos));
    if (with_rst) begin
      pos        = 0;
      model_done = 0;
    end else if (!model_done) begin
      pos++;
      if (pos == 65536) begin
        pos        = 0;
        model_done = 1;
      end
    end
  endtask

  task automatic idleCycle();
    @(posedge pclk);
    #1;
    i_region_active = 1'b0;
    i_ram_addr_rst  = 1'b0;
  endtask

  task automatic framePulse();
    @(posedge pclk);
    #1;
    i_region_active = 1'b0;
    i_ram_addr_rst  = 1'b1;
    pos        = 0;
    model_done = 0;
  endtask

  // Monitor: data check for the previous read, then address check for the
  // current one; sampled on the falling edge.
  initial begin : monitor
    bit data_pending;
    int data_addr;
    int e;
    data_pending = 0;
    data_addr    = 0;
    forever begin
      @(negedge pclk);
      if (o_frame_done)
        fd_count++;
      if (data_pending)
        checkOutput("region_data", int'(o_region_data), int'(ram_word(data_addr)));
      data_pending = 0;
      if (o_rd_en) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_rd_en", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rd_addr", int'(o_rd_addr), e);
          data_pending = 1;
          data_addr    = e;
        end
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : stimulus
    rst_n           = 1'b0;
    i_ram_addr_rst  = 1'b0;
    i_region_active = 1'b1;

    // Reset held with a request pending: nothing may be read
    @(negedge pclk);
    checkOutput("reset_rd_en", int'(o_rd_en), 0);
    checkOutput("reset_rd_addr", int'(o_rd_addr), 0);
    checkOutput("reset_frame_done", int'(o_frame_done), 0);
    checkOutput("reset_overrun", int'(o_overrun), 0);
    @(posedge pclk);
    #1;
    rst_n           = 1'b1;
    i_region_active = 1'b0;

    // Full contiguous frame: 65536 requests, last reads 4095
    for (int i = 0; i < 65536; i++)
      applyStimulus(1'b0);
    idleCycle();
    @(negedge pclk);
    checkOutput("frame_done_pulse", int'(o_frame_done), 1);
    idleCycle();
    @(negedge pclk);
    checkOutput("frame_done_clear", int'(o_frame_done), 0);

    // Request after completion: no read, sticky overrun
    applyStimulus(1'b0);
    @(negedge pclk);
    checkOutput("overrun_rd_en", int'(o_rd_en), 0);
    idleCycle();
    @(negedge pclk);
    checkOutput("overrun_set", int'(o_overrun), 1);
    repeat (3) idleCycle();
    @(negedge pclk);
    checkOutput("overrun_sticky", int'(o_overrun), 1);
    framePulse();
    idleCycle();
    @(negedge pclk);
    checkOutput("overrun_cleared", int'(o_overrun), 0);

    // Two output lines with 5-cycle gaps every 7 requests
    for (int i = 0; i < 512; i++) begin
      applyStimulus(1'b0);
      if ((i % 7) == 6) begin
        for (int g = 0; g < 5; g++) begin
          idleCycle();
          @(negedge pclk);
          checkOutput("gap_rd_en", int'(o_rd_en), 0);
        end
      end
    end

    // Walk on to output pixel (160,60), i.e. source address 1000
    while (pos < 15520)
      applyStimulus(1'b0);
    applyStimulus(1'b1);
    @(negedge pclk);
    checkOutput("midframe_addr", int'(o_rd_addr), 1000);
    checkOutput("midframe_rd_en", int'(o_rd_en), 1);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0);
    idleCycle();

    // Short asynchronous reset pulse between clock edges
    @(negedge pclk);
    checkOutput("pre_async_addr", int'(o_rd_addr), 2);
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("async_rst_addr", int'(o_rd_addr), 0);
    #1;
    rst_n      = 1'b1;
    pos        = 0;
    model_done = 0;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0);
    repeat (3) idleCycle();
    @(negedge pclk);
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("frame_done_count", fd_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
